// File: rtl/adc_frame_packer.sv
// adc_frame_packer
// Packs one ADC channel sweep into a FIFO frame: one header word, then two
// 16-bit samples per 32-bit word (low half = earlier channel). A frame is
// only started when the FIFO can take all of it, so writes are never gated
// mid-frame. Dropped sweeps are counted, and they still consume a sequence
// number so the host sees the gap.
module adc_frame_packer #(
  parameter logic [7:0]  HDR_TAG = 8'hA5,
  parameter logic [15:0] PAD_OK  = 16'h0000,
  parameter logic [15:0] PAD_ERR = 16'hFFFF
) (
  input  logic        sclk_i,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  channel_enable_count,
  input  logic [7:0]  data_valid,
  input  logic [15:0] ch1_data,
  input  logic [15:0] ch2_data,
  input  logic [15:0] ch3_data,
  input  logic [15:0] ch4_data,
  input  logic [15:0] ch5_data,
  input  logic [15:0] ch6_data,
  input  logic [15:0] ch7_data,
  input  logic [15:0] ch8_data,
  input  logic        fifo_prog_full,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        frame_done,
  output logic [15:0] overflow_count,
  output logic        seq_err,
  input  logic        clear_stats,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  // An output slot is {write, frame_done, data}. A slot with write=0 and
  // frame_done=1 is a bare end-of-frame pulse; all-zero means "nothing".
  localparam int SlotW = 34;

  state_t          state_q;
  logic [3:0]      numCh_q;
  logic [3:0]      expCh_q;
  logic [15:0]     seq_q;
  logic [15:0]     pend_q;
  logic            pendValid_q;
  logic [15:0]     ovf_q;
  logic            seqErr_q;
  logic [31:0]     din_q;
  logic            wr_q;
  logic            done_q;
  logic [SlotW-1:0] queue0_q;
  logic [SlotW-1:0] queue1_q;

  logic             strobe;
  logic             isCh1;
  logic [15:0]      sample;
  logic [3:0]       nClamp;
  logic             admitOk;
  logic             flushNow;
  logic             oneCh;
  logic             inOrder;
  logic             lastCh;
  logic [31:0]      hdrWord;
  logic [31:0]      flushWord;
  logic [SlotW-1:0] emit0_d;
  logic [SlotW-1:0] emit1_d;
  logic [SlotW-1:0] emit2_d;

  assign strobe = (data_valid != 8'd0);
  assign isCh1  = (data_valid == 8'd1);

  assign fifo_din       = din_q;
  assign fifo_wr_en     = wr_q;
  assign frame_done     = done_q;
  assign overflow_count = ovf_q;
  assign seq_err        = seqErr_q;
  assign busy           = (state_q == S_COLLECT);

  // Select the sample register named by the current channel strobe.
  always_comb begin
    sample = 16'h0000;
    case (data_valid)
      8'd1:    sample = ch1_data;
      8'd2:    sample = ch2_data;
      8'd3:    sample = ch3_data;
      8'd4:    sample = ch4_data;
      8'd5:    sample = ch5_data;
      8'd6:    sample = ch6_data;
      8'd7:    sample = ch7_data;
      8'd8:    sample = ch8_data;
      default: sample = 16'h0000;
    endcase
  end

  // Frame-level decisions for the current strobe; only eight channels exist.
  always_comb begin
    nClamp    = (channel_enable_count > 4'd8) ? 4'd8 : channel_enable_count;
    admitOk   = enable && (nClamp != 4'd0) && !fifo_prog_full;
    flushNow  = (state_q == S_COLLECT) && pendValid_q;
    oneCh     = (nClamp == 4'd1);
    inOrder   = (data_valid == {4'h0, expCh_q});
    lastCh    = (data_valid == {4'h0, numCh_q});
    hdrWord   = {HDR_TAG, 4'h0, nClamp, seq_q};
    flushWord = {PAD_ERR, pend_q};
  end

  // Build the ordered list of words this strobe produces: an error flush
  // comes first, then the header, then the single-channel final word.
  always_comb begin
    emit0_d = '0;
    emit1_d = '0;
    emit2_d = '0;
    if (isCh1) begin
      if (flushNow) begin
        emit0_d = {1'b1, 1'b1, flushWord};
        if (admitOk) begin
          emit1_d = {1'b1, 1'b0, hdrWord};
          if (oneCh) begin
            emit2_d = {1'b1, 1'b1, PAD_OK, ch1_data};
          end
        end
      end else if (admitOk) begin
        emit0_d = {1'b1, 1'b0, hdrWord};
        if (oneCh) begin
          emit1_d = {1'b1, 1'b1, PAD_OK, ch1_data};
        end
      end
    end else if (strobe && (state_q == S_COLLECT)) begin
      if (inOrder) begin
        if (!data_valid[0]) begin
          emit0_d = {1'b1, lastCh, sample, pend_q};
        end else if (lastCh) begin
          emit0_d = {1'b1, 1'b1, PAD_OK, sample};
        end
      end else begin
        emit0_d = {pendValid_q, 1'b1, flushWord};
      end
    end
  end

  // Frame FSM, sequence/statistics counters and registered FIFO outputs.
  always_ff @(posedge sclk_i or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      numCh_q     <= 4'd0;
      expCh_q     <= 4'd0;
      seq_q       <= 16'h0000;
      pend_q      <= 16'h0000;
      pendValid_q <= 1'b0;
      ovf_q       <= 16'h0000;
      seqErr_q    <= 1'b0;
      din_q       <= 32'h0000_0000;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      queue0_q    <= '0;
      queue1_q    <= '0;
    end else begin
      if (strobe) begin
        wr_q     <= emit0_d[33];
        done_q   <= emit0_d[32];
        if (emit0_d[33]) begin
          din_q <= emit0_d[31:0];
        end
        queue0_q <= emit1_d;
        queue1_q <= emit2_d;
      end else begin
        wr_q     <= queue0_q[33];
        done_q   <= queue0_q[32];
        if (queue0_q[33]) begin
          din_q <= queue0_q[31:0];
        end
        queue0_q <= queue1_q;
        queue1_q <= '0;
      end

      if (isCh1) begin
        if (state_q == S_COLLECT) begin
          seqErr_q <= 1'b1;
        end
        pendValid_q <= 1'b0;
        if (!enable || (nClamp == 4'd0)) begin
          state_q <= S_IDLE;
        end else if (fifo_prog_full) begin
          state_q <= S_DROP;
          seq_q   <= seq_q + 16'd1;
          if (ovf_q != 16'hFFFF) begin
            ovf_q <= ovf_q + 16'd1;
          end
        end else begin
          numCh_q <= nClamp;
          seq_q   <= seq_q + 16'd1;
          expCh_q <= 4'd2;
          if (oneCh) begin
            state_q <= S_IDLE;
          end else begin
            state_q     <= S_COLLECT;
            pend_q      <= ch1_data;
            pendValid_q <= 1'b1;
          end
        end
      end else if (strobe && (state_q == S_COLLECT)) begin
        if (inOrder) begin
          expCh_q <= expCh_q + 4'd1;
          if (!data_valid[0]) begin
            pendValid_q <= 1'b0;
          end else if (!lastCh) begin
            pend_q      <= sample;
            pendValid_q <= 1'b1;
          end
          if (lastCh) begin
            state_q     <= S_IDLE;
            pendValid_q <= 1'b0;
          end
        end else begin
          seqErr_q    <= 1'b1;
          pendValid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      end

      if (clear_stats) begin
        ovf_q    <= 16'h0000;
        seqErr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer
// Directed bench: each channel strobe is followed by three observed cycles,
// and the words seen are compared against hand-computed frame contents.
module tb_adc_frame_packer;

  logic        sclk_i;
  logic        rst;
  logic        enable;
  logic [3:0]  channel_enable_count;
  logic [7:0]  data_valid;
  logic [15:0] ch1_data, ch2_data, ch3_data, ch4_data;
  logic [15:0] ch5_data, ch6_data, ch7_data, ch8_data;
  logic        fifo_prog_full;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        frame_done;
  logic [15:0] overflow_count;
  logic        seq_err;
  logic        clear_stats;
  logic        busy;

  int checks;
  int errors;

  logic        obsWr[3];
  logic [31:0] obsDin[3];
  logic        obsDone[3];
  logic        obsBusy;

  adc_frame_packer dut (
    .sclk_i               (sclk_i),
    .rst                  (rst),
    .enable               (enable),
    .channel_enable_count (channel_enable_count),
    .data_valid           (data_valid),
    .ch1_data             (ch1_data),
    .ch2_data             (ch2_data),
    .ch3_data             (ch3_data),
    .ch4_data             (ch4_data),
    .ch5_data             (ch5_data),
    .ch6_data             (ch6_data),
    .ch7_data             (ch7_data),
    .ch8_data             (ch8_data),
    .fifo_prog_full       (fifo_prog_full),
    .fifo_din             (fifo_din),
    .fifo_wr_en           (fifo_wr_en),
    .frame_done           (frame_done),
    .overflow_count       (overflow_count),
    .seq_err              (seq_err),
    .clear_stats          (clear_stats),
    .busy                 (busy)
  );

  // 100 MHz sample clock.
  initial begin
    sclk_i = 1'b0;
    forever #5 sclk_i = ~sclk_i;
  end

  // Pulse one channel strobe, then record the three following cycles.
  task automatic applyStimulus(input logic [7:0] ch);
    @(negedge sclk_i);
    data_valid = ch;
    @(negedge sclk_i);
    data_valid = 8'd0;
    obsBusy = busy;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge sclk_i);
      obsWr[i]   = fifo_wr_en;
      obsDin[i]  = fifo_din;
      obsDone[i] = frame_done;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    enable = 1'b1;
    channel_enable_count = 4'd4;
    data_valid = 8'd0;
    fifo_prog_full = 1'b0;
    clear_stats = 1'b0;
    ch1_data = 16'h1001; ch2_data = 16'h1002; ch3_data = 16'h1003; ch4_data = 16'h1004;
    ch5_data = 16'h1005; ch6_data = 16'h1006; ch7_data = 16'h1007; ch8_data = 16'h1008;
    repeat (3) @(negedge sclk_i);
    checkOutput("rst_din", fifo_din, 32'h0);
    checkOutput("rst_wr", {31'd0, fifo_wr_en}, 32'd0);
    checkOutput("rst_done", {31'd0, frame_done}, 32'd0);
    checkOutput("rst_ovf", {16'd0, overflow_count}, 32'd0);
    checkOutput("rst_seqerr", {31'd0, seq_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Sweep 1, N=4.
    applyStimulus(8'd1);
    checkOutput("s1_hdr_wr", {31'd0, obsWr[0]}, 32'd1);
    checkOutput("s1_hdr", obsDin[0], 32'hA504_0000);
    checkOutput("s1_hdr_only", {31'd0, obsWr[1]}, 32'd0);
    checkOutput("s1_busy", {31'd0, obsBusy}, 32'd1);
    applyStimulus(8'd2);
    checkOutput("s1_w1", obsDin[0], 32'h1002_1001);
    checkOutput("s1_w1_done", {31'd0, obsDone[0]}, 32'd0);
    applyStimulus(8'd3);
    checkOutput("s1_ch3_nowr", {31'd0, obsWr[0]}, 32'd0);
    applyStimulus(8'd4);
    checkOutput("s1_w2_wr", {31'd0, obsWr[0]}, 32'd1);
    checkOutput("s1_w2", obsDin[0], 32'h1004_1003);
    checkOutput("s1_w2_done", {31'd0, obsDone[0]}, 32'd1);
    checkOutput("s1_idle", {31'd0, obsBusy}, 32'd0);

    // Sweep 2, seq 1.
    applyStimulus(8'd1);
    checkOutput("s2_hdr", obsDin[0], 32'hA504_0001);
    applyStimulus(8'd2);
    applyStimulus(8'd3);
    applyStimulus(8'd4);
    checkOutput("s2_last", obsDin[0], 32'h1004_1003);

    // N=3, seq 2.
    channel_enable_count = 4'd3;
    applyStimulus(8'd1);
    checkOutput("n3_hdr", obsDin[0], 32'hA503_0002);
    applyStimulus(8'd2);
    checkOutput("n3_w1", obsDin[0], 32'h1002_1001);
    applyStimulus(8'd3);
    checkOutput("n3_w2_wr", {31'd0, obsWr[0]}, 32'd1);
    checkOutput("n3_w2", obsDin[0], 32'h0000_1003);
    checkOutput("n3_w2_done", {31'd0, obsDone[0]}, 32'd1);

    // N=1, seq 3: header then padded word on the next cycle.
    channel_enable_count = 4'd1;
    applyStimulus(8'd1);
    checkOutput("n1_hdr", obsDin[0], 32'hA501_0003);
    checkOutput("n1_hdr_done", {31'd0, obsDone[0]}, 32'd0);
    checkOutput("n1_w1_wr", {31'd0, obsWr[1]}, 32'd1);
    checkOutput("n1_w1", obsDin[1], 32'h0000_1001);
    checkOutput("n1_w1_done", {31'd0, obsDone[1]}, 32'd1);
    checkOutput("n1_busy", {31'd0, obsBusy}, 32'd0);

    // Dropped sweep (seq 4 consumed).
    channel_enable_count = 4'd4;
    fifo_prog_full = 1'b1;
    applyStimulus(8'd1);
    fifo_prog_full = 1'b0;
    checkOutput("drop_wr0", {31'd0, obsWr[0]}, 32'd0);
    checkOutput("drop_wr1", {31'd0, obsWr[1]}, 32'd0);
    checkOutput("drop_ovf", {16'd0, overflow_count}, 32'd1);
    applyStimulus(8'd2);
    checkOutput("drop_ch2", {31'd0, obsWr[0]}, 32'd0);
    applyStimulus(8'd3);
    applyStimulus(8'd4);
    checkOutput("drop_seqerr", {31'd0, seq_err}, 32'd0);

    // Missing channel 3.
    applyStimulus(8'd1);
    checkOutput("gap_hdr", obsDin[0], 32'hA504_0005);
    applyStimulus(8'd2);
    checkOutput("gap_w1", obsDin[0], 32'h1002_1001);
    applyStimulus(8'd4);
    checkOutput("gap_nowr", {31'd0, obsWr[0]}, 32'd0);
    checkOutput("gap_done", {31'd0, obsDone[0]}, 32'd1);
    checkOutput("gap_seqerr", {31'd0, seq_err}, 32'd1);
    checkOutput("gap_busy", {31'd0, obsBusy}, 32'd0);

    // Premature channel 1 flushes the pending half.
    applyStimulus(8'd1);
    checkOutput("ok_hdr", obsDin[0], 32'hA504_0006);
    applyStimulus(8'd2);
    applyStimulus(8'd3);
    applyStimulus(8'd1);
    checkOutput("flush_w", obsDin[0], 32'hFFFF_1003);
    checkOutput("flush_wr", {31'd0, obsWr[0]}, 32'd1);
    checkOutput("flush_hdr", obsDin[1], 32'hA504_0007);
    checkOutput("flush_hdr_wr", {31'd0, obsWr[1]}, 32'd1);

    // Clear statistics.
    @(negedge sclk_i);
    clear_stats = 1'b1;
    @(negedge sclk_i);
    clear_stats = 1'b0;
    checkOutput("clr_seqerr", {31'd0, seq_err}, 32'd0);
    checkOutput("clr_ovf", {16'd0, overflow_count}, 32'd0);

    // Reset mid-frame.
    applyStimulus(8'd2);
    checkOutput("pre_rst_w1", obsDin[0], 32'h1002_1001);
    @(negedge sclk_i);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_din", fifo_din, 32'h0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge sclk_i);
    rst = 1'b0;
    applyStimulus(8'd3);
    checkOutput("post_rst_ch3", {31'd0, obsWr[0] | obsWr[1] | obsWr[2]}, 32'd0);
    applyStimulus(8'd4);
    checkOutput("post_rst_ch4", {31'd0, obsWr[0] | obsDone[0]}, 32'd0);
    applyStimulus(8'd1);
    checkOutput("post_rst_hdr", obsDin[0], 32'hA504_0000);
    applyStimulus(8'd2);
    applyStimulus(8'd3);
    applyStimulus(8'd4);

    // Disabled: no frame, no sequence step.
    enable = 1'b0;
    applyStimulus(8'd1);
    checkOutput("dis_nowr", {31'd0, obsWr[0]}, 32'd0);
    checkOutput("dis_busy", {31'd0, obsBusy}, 32'd0);
    enable = 1'b1;

    // N above 8 clamps to 8.
    channel_enable_count = 4'd12;
    applyStimulus(8'd1);
    checkOutput("clamp_hdr", obsDin[0], 32'hA508_0001);
    for (int k = 2; k <= 8; k++) applyStimulus(8'(k));
    checkOutput("clamp_last", obsDin[0], 32'h1008_1007);
    checkOutput("clamp_done", {31'd0, obsDone[0]}, 32'd1);

    // N=0 admits nothing; stray strobe in idle is harmless.
    channel_enable_count = 4'd0;
    applyStimulus(8'd1);
    checkOutput("n0_nowr", {31'd0, obsWr[0]}, 32'd0);
    applyStimulus(8'd3);
    checkOutput("idle_stray", {31'd0, seq_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
